// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the RISC-V load/store unit: FSM states,
// access size codes, alignment check, byte-enable and load-extension helpers.
package riscv_lsu_pkg;

   // Size codes as produced by the decoder's mem_size_o
   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Legal size with natural alignment; sizes 3, 6 and 7 never pass
   function automatic logic access_ok(input logic [2:0] size, input logic [1:0] a);
      case (size)
         LDST_B, LDST_BU: access_ok = 1'b1;
         LDST_H, LDST_HU: access_ok = ~a[0];
         LDST_W:          access_ok = (a == 2'b00);
         default:         access_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] a);
      case (size)
         LDST_B, LDST_BU: byte_enable = 4'b0001 << a;
         LDST_H, LDST_HU: byte_enable = 4'b0011 << {a[1], 1'b0};
         default:         byte_enable = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] a,
                                               input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{a, 3'b000} +: 8];
      h = rdata[{a[1], 4'b0000} +: 16];
      case (size)
         LDST_B:  load_extend = {{24{b[7]}}, b};
         LDST_BU: load_extend = {24'h000000, b};
         LDST_H:  load_extend = {{16{h[15]}}, h};
         LDST_HU: load_extend = {16'h0000, h};
         default: load_extend = rdata;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the LSU: byte enables, store-data replication,
// misalignment detection on the issuing request, and load extraction/extension.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [2:0]  ld_size,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign,
   output logic [31:0] load_data
);

   logic byte_sel;
   logic half_sel;

   assign byte_sel  = (size == LDST_B) || (size == LDST_BU);
   assign half_sel  = (size == LDST_H) || (size == LDST_HU);
   assign misalign  = ~access_ok(size, offset);
   assign be        = byte_enable(size, offset);
   assign load_data = load_extend(ld_size, ld_offset, rdata);

   // Every lane carries the datum so the memory can pick by byte enable alone
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata[8*gi +: 8] = byte_sel ? store_data[7:0] :
                                   half_sel ? store_data[8*(gi%2) +: 8] :
                                              store_data[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues one req/ack data-bus access per request, stalls the
// core until it completes, and returns extended load data for writeback.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_stall_req_o,
   output logic [31:0] lsu_data_o,
   output logic        lsu_misalign_o,
   output logic        lsu_bus_err_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   input  logic        data_ack_i
);

   lsu_state_t  state_reg, state_next;
   logic        we_reg;
   logic [2:0]  size_reg;
   logic [1:0]  offset_reg;
   logic        data_req_reg, data_we_reg, bus_err_reg;
   logic [3:0]  be_reg;
   logic [31:0] addr_reg, wdata_reg, lsu_data_reg;

   logic [3:0]  be_comb;
   logic [31:0] wdata_comb, load_data_comb;
   logic        misalign_comb;
   logic        timeout;
   logic        issue, finish, stall_comb, misalign_pulse;

   riscv_lsu_align u_align (
      .size       (lsu_size_i),
      .offset     (lsu_addr_i[1:0]),
      .store_data (lsu_data_i),
      .ld_size    (size_reg),
      .ld_offset  (offset_reg),
      .rdata      (data_rdata_i),
      .be         (be_comb),
      .wdata      (wdata_comb),
      .misalign   (misalign_comb),
      .load_data  (load_data_comb)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      issue          = 1'b0;
      finish         = 1'b0;
      stall_comb     = 1'b0;
      misalign_pulse = 1'b0;
      case (state_reg)
         IDLE: begin
            if (lsu_req_i) begin
               if (misalign_comb) begin
                  misalign_pulse = 1'b1;
               end else begin
                  issue      = 1'b1;
                  stall_comb = 1'b1;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            stall_comb = 1'b1;
            if (data_ack_i || timeout) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_reg       <= 1'b0;
         size_reg     <= 3'd0;
         offset_reg   <= 2'd0;
         data_req_reg <= 1'b0;
         data_we_reg  <= 1'b0;
         be_reg       <= 4'd0;
         addr_reg     <= 32'd0;
         wdata_reg    <= 32'd0;
         lsu_data_reg <= 32'd0;
         bus_err_reg  <= 1'b0;
      end else begin
         bus_err_reg <= 1'b0;
         if (issue) begin
            we_reg       <= lsu_we_i;
            size_reg     <= lsu_size_i;
            offset_reg   <= lsu_addr_i[1:0];
            data_req_reg <= 1'b1;
            data_we_reg  <= lsu_we_i;
            be_reg       <= be_comb;
            addr_reg     <= {lsu_addr_i[31:2], 2'b00};
            wdata_reg    <= wdata_comb;
         end else if (finish) begin
            data_req_reg <= 1'b0;
            // Ack has priority over a timeout landing in the same cycle
            if (data_ack_i) begin
               if (!we_reg) lsu_data_reg <= load_data_comb;
            end else begin
               bus_err_reg <= 1'b1;
            end
         end
      end
   end

   generate
      if (TIMEOUT_CYCLES != 0) begin : g_timeout
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_inc;

         assign cnt_inc = cnt_reg + 1'b1;
         assign timeout = (state_reg == REQ) && !data_ack_i && (cnt_inc == CW'(TIMEOUT_CYCLES));

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                                             cnt_reg <= '0;
            else if ((state_reg == REQ) && !data_ack_i && !timeout) cnt_reg <= cnt_inc;
            else                                                   cnt_reg <= '0;
         end
      end else begin : g_no_timeout
         assign timeout = 1'b0;
      end
   endgenerate

   // Combinational handshakes are forced low while reset is held
   assign lsu_stall_req_o = stall_comb & ~rst_i;
   assign lsu_misalign_o  = misalign_pulse & ~rst_i;
   assign lsu_bus_err_o   = bus_err_reg;
   assign lsu_data_o      = lsu_data_reg;
   assign data_req_o      = data_req_reg;
   assign data_we_o       = data_we_reg;
   assign data_be_o       = be_reg;
   assign data_addr_o     = addr_reg;
   assign data_wdata_o    = wdata_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed scoreboard bench for riscv_lsu with a 4-cycle ack timeout.
module tb_riscv_lsu;

   localparam int TO = 4;
   localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i, lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_data_i;
   logic        lsu_stall_req_o;
   logic [31:0] lsu_data_o;
   logic        lsu_misalign_o, lsu_bus_err_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic [31:0] data_rdata_i;
   logic        data_ack_i;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] ld_q[$];
   logic [31:0] last_load;
   int          passed = 0;
   int          total  = 0;
   int          cyc;

   riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
      .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
      .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   function automatic logic [3:0] m_be(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] r;
      r = 4'b0000;
      if (size == SZ_B || size == SZ_BU)      r[a] = 1'b1;
      else if (size == SZ_H || size == SZ_HU) r = a[1] ? 4'b1100 : 4'b0011;
      else                                    r = 4'b1111;
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
      if (size == SZ_B || size == SZ_BU) return {4{d[7:0]}};
      if (size == SZ_H || size == SZ_HU) return {2{d[15:0]}};
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] size, input logic [1:0] a,
                                          input logic [31:0] rd);
      logic [31:0] sb, sh;
      sb = rd >> (8 * a);
      sh = rd >> (a[1] ? 16 : 0);
      case (size)
         SZ_B:    return {{24{sb[7]}}, sb[7:0]};
         SZ_BU:   return {24'd0, sb[7:0]};
         SZ_H:    return {{16{sh[15]}}, sh[15:0]};
         SZ_HU:   return {16'd0, sh[15:0]};
         default: return rd;
      endcase
   endfunction

   // One full access; ack_at = REQ cycle carrying the ack (0 = never)
   task automatic access(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int ack_at);
      bus_exp_t    e;
      logic        timed_out;
      int          n, exp_n;
      logic        done;
      logic [31:0] exp_ld;
      timed_out = (ack_at == 0) || (ack_at > TO);
      exp_n     = timed_out ? TO : ack_at;
      lsu_req_i  = 1'b1;
      lsu_we_i   = we;
      lsu_size_i = size;
      lsu_addr_i = addr;
      lsu_data_i = data;
      #1;
      check({name, "_issue_stall"}, 32'(lsu_stall_req_o), 32'd1);
      check({name, "_issue_misalign"}, 32'(lsu_misalign_o), 32'd0);
      bus_q.push_back('{we: we, be: m_be(size, addr[1:0]),
                        addr: {addr[31:2], 2'b00}, wdata: m_wdata(size, data)});
      if (!we && !timed_out) last_load = m_load(size, addr[1:0], rdata);
      ld_q.push_back(last_load);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      e = bus_q.pop_front();
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         n++;
         check({name, "_req"}, 32'(data_req_o), 32'd1);
         check({name, "_req_stall"}, 32'(lsu_stall_req_o), 32'd1);
         check({name, "_we"}, 32'(data_we_o), 32'(e.we));
         check({name, "_be"}, 32'(data_be_o), 32'(e.be));
         check({name, "_addr"}, data_addr_o, e.addr);
         check({name, "_wdata"}, data_wdata_o, e.wdata);
         if (n == ack_at) begin
            data_ack_i   = 1'b1;
            data_rdata_i = rdata;
         end
         @(posedge clk_i); #1;
         data_ack_i   = 1'b0;
         data_rdata_i = 32'h5A5A_0F0F;
         if (!lsu_stall_req_o) done = 1'b1;
      end
      check({name, "_done_reached"}, 32'(done), 32'd1);
      check({name, "_req_cycles"}, 32'(n), 32'(exp_n));
      check({name, "_done_req_low"}, 32'(data_req_o), 32'd0);
      check({name, "_bus_err"}, 32'(lsu_bus_err_o), 32'(timed_out));
      exp_ld = ld_q.pop_front();
      check({name, "_lsu_data"}, lsu_data_o, exp_ld);
      // A request presented during DONE must not be taken
      lsu_req_i  = 1'b1;
      lsu_we_i   = 1'b0;
      lsu_size_i = SZ_W;
      lsu_addr_i = 32'h0000_0200;
      #1;
      check({name, "_done_stall"}, 32'(lsu_stall_req_o), 32'd0);
      lsu_req_i = 1'b0;
      @(posedge clk_i); #1;
      check({name, "_idle_req"}, 32'(data_req_o), 32'd0);
      check({name, "_err_pulse"}, 32'(lsu_bus_err_o), 32'd0);
      $display("txn %s we=%0d size=%0d addr=0x%08h req_cycles=%0d lsu_data=0x%08h",
               name, we, size, addr, n, lsu_data_o);
   endtask

   task automatic misalign(input string name, input logic [2:0] size, input logic [31:0] addr);
      lsu_req_i  = 1'b1;
      lsu_we_i   = 1'b0;
      lsu_size_i = size;
      lsu_addr_i = addr;
      #1;
      check({name, "_pulse"}, 32'(lsu_misalign_o), 32'd1);
      check({name, "_stall"}, 32'(lsu_stall_req_o), 32'd0);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      #1;
      check({name, "_pulse_end"}, 32'(lsu_misalign_o), 32'd0);
      check({name, "_no_req"}, 32'(data_req_o), 32'd0);
      check({name, "_data_kept"}, lsu_data_o, last_load);
      $display("txn %s size=%0d addr=0x%08h misalign", name, size, addr);
   endtask

   initial begin
      rst_i = 1'b1;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
      lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
      data_rdata_i = 32'd0; data_ack_i = 1'b0;
      last_load = 32'd0;
      @(posedge clk_i); #1;
      check("rst_req", 32'(data_req_o), 32'd0);
      check("rst_stall", 32'(lsu_stall_req_o), 32'd0);
      check("rst_be", 32'(data_be_o), 32'd0);
      check("rst_lsu_data", lsu_data_o, 32'd0);
      check("rst_err", 32'(lsu_bus_err_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      access("sw",  1'b1, SZ_W,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 1);
      access("sb",  1'b1, SZ_B,  32'h0000_0103, 32'h0000_00A5, 32'h0, 1);
      access("sh",  1'b1, SZ_H,  32'h0000_0106, 32'h1234_BEEF, 32'h0, 2);
      access("lb",  1'b0, SZ_B,  32'h0000_0102, 32'h0, 32'h0080_FF00, 1);
      access("lbu", 1'b0, SZ_BU, 32'h0000_0102, 32'h0, 32'h0080_FF00, 1);
      access("lhu", 1'b0, SZ_HU, 32'h0000_0102, 32'h0, 32'h0080_FF00, 1);
      access("lh",  1'b0, SZ_H,  32'h0000_0100, 32'h0, 32'h0080_FF00, 3);
      access("lw",  1'b0, SZ_W,  32'h0000_0108, 32'h0, 32'h1234_5678, 2);
      access("sw2", 1'b1, SZ_W,  32'h0000_010C, 32'hCAFE_F00D, 32'h0, 1);

      misalign("mis_lw",  SZ_W,  32'h0000_0101);
      misalign("mis_lh",  SZ_H,  32'h0000_0103);
      misalign("mis_sz3", 3'd3,  32'h0000_0100);
      misalign("mis_sz7", 3'd7,  32'h0000_0100);

      access("lw_timeout", 1'b0, SZ_W, 32'h0000_0110, 32'h0, 32'hFFFF_0000, 0);
      access("lw_ack4",    1'b0, SZ_W, 32'h0000_0114, 32'h0, 32'h8765_4321, 4);

      // Ack while idle must not load anything
      data_ack_i   = 1'b1;
      data_rdata_i = 32'h1111_2222;
      @(posedge clk_i); #1;
      data_ack_i = 1'b0;
      check("stray_ack_data", lsu_data_o, last_load);
      check("stray_ack_req", 32'(data_req_o), 32'd0);
      $display("txn stray_ack lsu_data=0x%08h", lsu_data_o);

      // Reset in the middle of a REQ phase
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = SZ_W;
      lsu_addr_i = 32'h0000_0118; lsu_data_i = 32'h55AA_55AA;
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      check("mid_rst_pre_req", 32'(data_req_o), 32'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      #1;
      check("mid_rst_req", 32'(data_req_o), 32'd0);
      check("mid_rst_stall", 32'(lsu_stall_req_o), 32'd0);
      check("mid_rst_wdata", data_wdata_o, 32'd0);
      check("mid_rst_addr", data_addr_o, 32'd0);
      check("mid_rst_lsu_data", lsu_data_o, 32'd0);
      last_load = 32'd0;
      $display("txn mid_req_reset req=%0d stall=%0d", data_req_o, lsu_stall_req_o);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      access("lbu_post_rst", 1'b0, SZ_BU, 32'h0000_0101, 32'h0, 32'h0000_AB00, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      cyc = 0;
      while (cyc < 5000) begin
         @(posedge clk_i);
         cyc++;
      end
      $display("FAIL watchdog observed=%0d cycles expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
